// File: rtl/adder_operand_loader_if.sv
// Bundles the switch/key inputs and the adder-facing bus of the operand loader.
// The slave side is the loader; the master side is the board or its stand-in.
interface adder_operand_loader_if #(
    parameter int bits = 2
);
    logic [bits-1:0] sw;
    logic            ci_sw;
    logic            key_n;
    logic [2*bits:0] add_sw;
    logic [bits:0]   add_ledr;
    logic [bits:0]   result;
    logic            result_valid;
    logic [1:0]      state;

    modport master (
        output sw, ci_sw, key_n, add_ledr,
        input  add_sw, result, result_valid, state
    );

    modport slave (
        input  sw, ci_sw, key_n, add_ledr,
        output add_sw, result, result_valid, state
    );
endinterface

// File: rtl/adder_operand_loader.sv
// Loads A, then B and carry-in, from switches on debounced key presses, drives the
// combinational adder with {ci, a, b} and latches its output as a held result.
module adder_operand_loader #(
    parameter int bits            = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    adder_operand_loader_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        SHOW    = 2'd3
    } state_e;

    logic             key_meta_q, key_s_q;
    logic             key_db_q, key_db_d;
    logic             key_db_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q;

    state_e           state_q;
    logic [2*bits:0]  add_sw_q;
    logic [bits:0]    result_q;
    logic             result_valid_q;

    // The debounced level only follows key_s after a full run of mismatching samples.
    always_comb begin
        cnt_d    = cnt_q;
        key_db_d = key_db_q;
        if (key_s_q == key_db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            key_db_d = key_s_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q    <= 1'b1;
            key_s_q       <= 1'b1;
            key_db_q      <= 1'b1;
            key_db_prev_q <= 1'b1;
            cnt_q         <= '0;
            press_q       <= 1'b0;
        end else begin
            key_meta_q    <= bus.key_n;
            key_s_q       <= key_meta_q;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_q;
            cnt_q         <= cnt_d;
            // Only the 1->0 edge of the debounced level is an event.
            press_q       <= key_db_prev_q & ~key_db_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= LOAD_A;
            add_sw_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (press_q) begin
                        add_sw_q[2*bits-1:bits] <= bus.sw;
                        state_q                 <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press_q) begin
                        add_sw_q[bits-1:0] <= bus.sw;
                        add_sw_q[2*bits]   <= bus.ci_sw;
                        state_q            <= COMPUTE;
                    end
                end
                // One cycle lets the external adder settle on the new operands.
                COMPUTE: begin
                    result_q       <= bus.add_ledr;
                    result_valid_q <= 1'b1;
                    state_q        <= SHOW;
                end
                SHOW: begin
                    if (press_q) begin
                        result_valid_q <= 1'b0;
                        state_q        <= LOAD_A;
                    end
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

    assign bus.add_sw       = add_sw_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.state        = state_q;
endmodule

// File: doc/adder_operand_loader.md
Name: adder_operand_loader

Overview:
- Upstream stage for the n-bit ripple-carry adder (n_ripple_carry_adder).
- Captures operand A, operand B and carry-in from board switches, one push-button press per step.
- Presents the packed {ci, a, b} vector on the adder's sw input, then registers the adder's ledr output as a held result.
- Lets the combinational adder be exercised by hand on the board with a stable, latched display.

Parameters:
- bits, 2, operand width; must match the adder's bits parameter.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before the debounced key level changes; must be ≥ 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  bits  data switches; operand value for the current load step.
- ci_sw  input  1  carry-in switch; sampled on the B-load press only.
- key_n  input  1  raw push button, active-low, asynchronous to clk, may bounce.
- add_sw  output  2*bits+1  to adder sw: [2*bits] = ci, [2*bits-1:bits] = a, [bits-1:0] = b.
- add_ledr  input  bits+1  from adder ledr: [bits] = carry-out, [bits-1:0] = sum.
- result  output  bits+1  registered copy of add_ledr.
- result_valid  output  1  high while result holds a completed sum.
- state  output  2  current FSM state, for LED debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - add_sw = 0, result = 0, result_valid = 0, state = LOAD_A (2'd0).
  - Debounced key = 1 (released), debounce counter = 0, sync flops = 1.
  - Applies mid-operation; all captured operands are discarded.
- Key synchroniser: key_n passes through 2 flip-flops to give key_s.
- Debounce counter:
  - Resets to 0 whenever key_s == key_db.
  - Otherwise increments each cycle.
  - When key_s != key_db for DEBOUNCE_CYCLES consecutive cycles: key_db <= key_s, counter <= 0.
  - Any mismatch gap shorter than DEBOUNCE_CYCLES is ignored.
- press: registered one-cycle pulse on a key_db 1→0 transition only. Release generates no event.
- Press latency: a clean key_n fall to the cycle press is high is exactly DEBOUNCE_CYCLES+3 rising edges (2 sync + DEBOUNCE_CYCLES + 1 pulse register).
- FSM; every transition is triggered only by press unless stated:
  - LOAD_A (0): on press, add_sw[2*bits-1:bits] <= sw; go to LOAD_B.
  - LOAD_B (1): on press, add_sw[bits-1:0] <= sw and add_sw[2*bits] <= ci_sw; go to COMPUTE.
  - COMPUTE (2): no press needed. After exactly one cycle in COMPUTE (adder settle), result <= add_ledr and result_valid <= 1; go to SHOW. A press arriving in COMPUTE is dropped.
  - SHOW (3): result and add_sw held. On press, result_valid <= 0 and go to LOAD_A. result keeps its old value until the next capture; add_sw keeps its old operands until overwritten.
- Switch changes without a press never alter add_sw.
- Width rule: result is bits+1 wide; carry-out is always preserved. Overflow a+b+ci = 2^(bits+1)-1 is representable; no wrap beyond carry.
- Holding the key produces exactly one press. Re-arming requires a debounced release first.

Test Plan (bits=2, DEBOUNCE_CYCLES=4):
- Reset: hold rst_n=0 for 3 cycles, then release → add_sw=5'b0, result=0, result_valid=0, state=0.
- Clean sequence: sw=2'b11, press; sw=2'b10, ci_sw=1, press → add_sw=5'b1_11_10. With a behavioural adder, result=3'b110 and result_valid=1 one cycle after entering COMPUTE, state=3. Press in SHOW → state=0, result_valid=0, result still 3'b110.
- Bounce rejection: key_n toggles low/high every 2 cycles for 20 cycles, then held low → exactly one press pulse, 7 cycles after the final stable fall; state advances by one only.
- Latency: a single clean key_n fall is followed by press high on exactly the 7th rising edge; a 3-cycle low glitch produces no press.
- Reset mid-operation: enter LOAD_B with a=2'b01, assert rst_n low asynchronously between clock edges → outputs clear immediately without waiting for a clock edge; state=0.
- Exhaustive: all 32 {ci,a,b} combinations loaded through the FSM → result == a+b+ci each time, including max case 3+3+1 = 3'b111.
